axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI4-Lite initiator that turns the core's single-outstanding load/store request port into AXI4-Lite read and write transactions toward the memory-side slave (the 64-bit data SRAM and MMIO). It sits between the LSU/IFU arbiter and the AXI crossbar. It holds exactly one transaction in flight and returns one response per request with the read data and the error status.

## Interface
Parameters:
- ADDR_W, 32, address width of the request port and the AR/AW channels
- DATA_W, 64, data width; the strobe width is DATA_W/8

Ports:
- ACLK  in  1  clock; all logic is on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address, passed through unmodified
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- resp_valid  out  1  one-cycle pulse when the transaction completes
- resp_rdata  out  DATA_W  read data; valid only while resp_valid is high after a read
- resp_err  out  1  RRESP or BRESP was not 2'b00
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in  ADDR_W/3/1/1  write address channel
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in  DATA_W/DATA_W/8/1/1  write data channel
- M_AXI_BRESP in/BVALID in/BREADY out  2/1/1  write response channel
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in  ADDR_W/3/1/1  read address channel
- M_AXI_RDATA/RRESP/RVALID in, RREADY out  DATA_W/2/1/1  read data channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- req_ready = (state == IDLE). This is combinational from state only and has no dependence on req_valid.
- IDLE with an accepted request:
  - Latch the address, data and strobes.
  - If req_wen = 0: go to RD_ADDR. If req_wen = 1: go to WR_REQ.
- RD_ADDR:
  - ARVALID = 1 and ARADDR is stable.
  - On ARVALID && ARREADY: go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: register RDATA into resp_rdata and set resp_err = (RRESP != 0). Pulse resp_valid and go to IDLE.
- WR_REQ:
  - AWVALID and WVALID both rise on entry.
  - Each channel drops independently after its own handshake. Two done flags track this.
  - When both handshakes are complete (including on the same cycle), go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: set resp_err = (BRESP != 0). Pulse resp_valid and go to IDLE.
  - resp_rdata holds its previous value.
- AWPROT and ARPROT are tied to 3'b000.
- AWADDR, WDATA, WSTRB and ARADDR come from the latched request and stay stable until the state returns to IDLE.
- There is no timeout. A slave that never responds stalls the block indefinitely.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, resp_valid and resp_err go to 0.
  - resp_rdata and all latched address/data/strobe registers go to 0.
  - req_ready is 1 once reset deasserts.
- Reset mid-transaction aborts the transaction with no response. The slave side is assumed to be reset by the same ARESET.
- All AXI outputs and resp_* are registered. No combinational path exists from any AXI input to any AXI output.
- Acceptance takes 1 cycle: the request is accepted at edge 0 and xVALID is high from cycle 1.
- A VALID output never drops before its handshake.
- After a handshake, VALID is low on the following cycle.
- resp_valid is high for exactly one cycle: the cycle after the R or B handshake. req_ready is also 1 in that cycle, so back-to-back requests are allowed.
- Read latency against a slave that asserts ARREADY one cycle after ARVALID and RVALID two cycles after the AR handshake:
  - AR handshake in cycle 2, R handshake in cycle 4, resp_valid in cycle 5.
  - Minimum possible read latency (ARREADY and RVALID already high) is resp_valid 3 cycles after acceptance.
- A write with AW and W accepted on the same edge passes through WR_REQ in one cycle.
- While in WR_REQ, BVALID from the slave is ignored until the state reaches WR_RESP. Compliant slaves never assert it early.

## Test plan
- Read, slave ARREADY at cycle 2 and RVALID at cycle 4 with RDATA=64'h0123_4567_89AB_CDEF, RRESP=0 -> ARADDR=32'h8000_0010 held from cycles 1-2; resp_valid in cycle 5 only; resp_rdata=64'h0123_4567_89AB_CDEF; resp_err=0.
- Write, addr 32'h8000_0008, data 64'hDEAD_BEEF_0000_FFFF, wstrb 8'h0F, WREADY 3 cycles after AWREADY -> AWVALID drops the cycle after its handshake while WVALID stays high until its own handshake; BREADY only after both handshakes; BRESP=0 gives resp_valid for one cycle with resp_err=0.
- Write with AWREADY=WREADY=1 on the same edge, then BVALID with BRESP=2'b10 -> single WR_REQ cycle; resp_err=1 in the resp_valid cycle.
- Back-to-back requests: keep req_valid high across a read followed by a write -> the second request is accepted in the resp_valid cycle of the first; no VALID glitches between them.
- Read with RVALID delayed 10 cycles and RRESP=2'b11 -> RREADY stays high throughout; ARVALID low after its handshake; resp_err=1.
- Assert ARESET while in RD_DATA -> all VALID/READY outputs and resp_valid go to 0 immediately; no resp_valid after release; the next read completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI4-Lite initiator for single-outstanding load/store requests
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,

  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,

  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,

  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,

  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,

  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,

  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                state;

  // Request fields captured at acceptance; they feed the AXI channels unchanged
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;

  // Write address and write data complete independently of each other
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_fin;
  logic                  w_fin;

  assign req_ready    = (state == IDLE);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // A channel counts as finished if it already handshook or is handshaking this cycle
  assign aw_fin = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_fin  = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);

  // Transaction sequencer with registered AXI handshake outputs and response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_wen) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            resp_rdata   <= M_AXI_RDATA;
            resp_err     <= (M_AXI_RRESP != 2'b00);
            resp_valid   <= 1'b1;
            state        <= IDLE;
          end
        end

        WR_REQ: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          // Both channels done: flags are cleared here so the next write starts clean
          if (aw_fin && w_fin) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            resp_err     <= (M_AXI_BRESP != 2'b00);
            resp_valid   <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed bench for axi_lite_master
module tb_axi_lite_master;

  logic        ACLK;
  logic        ARESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int n_vec = 0;
  int n_err = 0;

  axi_lite_master #(.ADDR_W(32), .DATA_W(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // One directed transaction: request fields, slave delays and expected response
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  resp;
    int          lat;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input int ar, input int r, input int aw,
                              input int w, input int b, input logic [1:0] resp, input int lat,
                              input logic err, input logic [63:0] rdata);
    vec_t v;
    v.wen = wen; v.addr = addr; v.data = data; v.strb = strb;
    v.ar_dly = ar; v.r_dly = r; v.aw_dly = aw; v.w_dly = w; v.b_dly = b;
    v.resp = resp; v.lat = lat; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_slave();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RDATA   = 64'h0;
  endtask

  // Issues one request, plays the slave with the vector's delays, checks channel protocol and response
  task automatic run_txn(input vec_t v, input string tag);
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit ar_done = 0, r_done = 0, aw_done = 0, w_done = 0, b_done = 0;
    bit p_ar_pend = 0, p_ar_hs = 0, p_aw_pend = 0, p_aw_hs = 0, p_w_pend = 0, p_w_hs = 0;
    bit got = 0;
    tick();
    clear_slave();
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wen ? v.data : 64'h0;
    req_wstrb = v.strb;
    @(negedge ACLK);
    chk({tag, ":req_ready_idle"}, {63'h0, req_ready}, 64'd1);
    chk({tag, ":resp_valid_idle"}, {63'h0, resp_valid}, 64'd0);
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (M_AXI_ARVALID) ar_cnt++;
      M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt > v.ar_dly);
      if (ar_done && !r_done) r_cnt++;
      M_AXI_RVALID = ar_done && !r_done && (r_cnt > v.r_dly);
      M_AXI_RDATA  = v.data;
      M_AXI_RRESP  = v.resp;
      if (M_AXI_AWVALID) aw_cnt++;
      M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt > v.aw_dly);
      if (M_AXI_WVALID) w_cnt++;
      M_AXI_WREADY = M_AXI_WVALID && (w_cnt > v.w_dly);
      if (aw_done && w_done && !b_done) b_cnt++;
      M_AXI_BVALID = aw_done && w_done && !b_done && (b_cnt > v.b_dly);
      M_AXI_BRESP  = v.resp;
      @(negedge ACLK);
      if (p_ar_pend) chk({tag, ":arvalid_hold"}, {63'h0, M_AXI_ARVALID}, 64'd1);
      if (p_ar_hs)   chk({tag, ":arvalid_drop"}, {63'h0, M_AXI_ARVALID}, 64'd0);
      if (p_aw_pend) chk({tag, ":awvalid_hold"}, {63'h0, M_AXI_AWVALID}, 64'd1);
      if (p_aw_hs)   chk({tag, ":awvalid_drop"}, {63'h0, M_AXI_AWVALID}, 64'd0);
      if (p_w_pend)  chk({tag, ":wvalid_hold"},  {63'h0, M_AXI_WVALID},  64'd1);
      if (p_w_hs)    chk({tag, ":wvalid_drop"},  {63'h0, M_AXI_WVALID},  64'd0);
      if (M_AXI_ARVALID) chk({tag, ":araddr"}, {32'h0, M_AXI_ARADDR}, {32'h0, v.addr});
      if (M_AXI_AWVALID) chk({tag, ":awaddr"}, {32'h0, M_AXI_AWADDR}, {32'h0, v.addr});
      if (M_AXI_WVALID) begin
        chk({tag, ":wdata"}, M_AXI_WDATA, v.data);
        chk({tag, ":wstrb"}, {56'h0, M_AXI_WSTRB}, {56'h0, v.strb});
      end
      if (M_AXI_RREADY) chk({tag, ":rready_early"}, {63'h0, ar_done}, 64'd1);
      if (ar_done && !r_done) chk({tag, ":rready_hold"}, {63'h0, M_AXI_RREADY}, 64'd1);
      if (M_AXI_BREADY) chk({tag, ":bready_early"}, {63'h0, aw_done && w_done}, 64'd1);
      if (aw_done && w_done && !b_done) chk({tag, ":bready_hold"}, {63'h0, M_AXI_BREADY}, 64'd1);
      if (resp_valid) begin
        got = 1;
        chk({tag, ":latency"}, 64'(c), 64'(v.lat));
        chk({tag, ":resp_err"}, {63'h0, resp_err}, {63'h0, v.err});
        chk({tag, ":resp_rdata"}, resp_rdata, v.rdata);
        chk({tag, ":req_ready_resp"}, {63'h0, req_ready}, 64'd1);
      end else begin
        chk({tag, ":req_ready_busy"}, {63'h0, req_ready}, 64'd0);
      end
      p_ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
      p_ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
      p_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
      p_aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
      p_w_hs    = M_AXI_WVALID && M_AXI_WREADY;
      p_w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
      if (p_ar_hs) ar_done = 1;
      if (p_aw_hs) aw_done = 1;
      if (p_w_hs)  w_done = 1;
      if (M_AXI_RVALID && M_AXI_RREADY) r_done = 1;
      if (M_AXI_BVALID && M_AXI_BREADY) b_done = 1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s:timeout: got no resp_valid expected one within 60 cycles", tag);
    end
    clear_slave();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    ARESET    = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 64'h0;
    req_wstrb = 8'h0;
    clear_slave();

    //             wen   addr          data                   strb   ar r  aw w  b  resp   lat err  expected rdata
    vecs[0] = mk(1'b0, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'h00, 1, 1, 0, 0, 0, 2'b00, 5,  1'b0, 64'h0123_4567_89AB_CDEF);
    vecs[1] = mk(1'b0, 32'h0000_0100, 64'h1111_2222_3333_4444, 8'h00, 0, 0, 0, 0, 0, 2'b10, 3,  1'b1, 64'h1111_2222_3333_4444);
    vecs[2] = mk(1'b0, 32'h0000_0200, 64'hA5A5_A5A5_5A5A_5A5A, 8'h00, 0, 10, 0, 0, 0, 2'b11, 13, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A);
    vecs[3] = mk(1'b1, 32'h8000_0008, 64'hDEAD_BEEF_0000_FFFF, 8'h0F, 0, 0, 0, 3, 0, 2'b00, 6,  1'b0, 64'hA5A5_A5A5_5A5A_5A5A);
    vecs[4] = mk(1'b1, 32'h0000_0300, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, 0, 0, 2, 2'b10, 5,  1'b1, 64'hA5A5_A5A5_5A5A_5A5A);
    vecs[5] = mk(1'b1, 32'h0000_0308, 64'h0F0F_0F0F_F0F0_F0F0, 8'hF0, 0, 0, 2, 0, 1, 2'b00, 6,  1'b0, 64'hA5A5_A5A5_5A5A_5A5A);
    vecs[6] = mk(1'b1, 32'h0000_0310, 64'h0000_0000_0000_0001, 8'h01, 0, 0, 1, 1, 0, 2'b01, 4,  1'b1, 64'hA5A5_A5A5_5A5A_5A5A);
    vecs[7] = mk(1'b0, 32'h4000_0000, 64'hFEDC_BA98_7654_3210, 8'h00, 2, 0, 0, 0, 0, 2'b00, 5,  1'b0, 64'hFEDC_BA98_7654_3210);

    // Reset state, visible before any clock edge
    #2;
    chk("rst_valids", {57'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                       M_AXI_RREADY, resp_valid, resp_err}, 64'h0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_addr", {M_AXI_ARADDR, M_AXI_AWADDR}, 64'h0);
    chk("rst_wdata", M_AXI_WDATA, 64'h0);
    chk("rst_wstrb", {56'h0, M_AXI_WSTRB}, 64'h0);
    chk("rst_prot", {58'h0, M_AXI_ARPROT, M_AXI_AWPROT}, 64'h0);
    tick();
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_req_ready", {63'h0, req_ready}, 64'd1);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data: everything drops at once, no response afterwards
    tick();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0020;
    M_AXI_ARREADY = 1'b1;
    @(negedge ACLK);
    tick();
    req_valid = 1'b0;
    @(negedge ACLK);
    chk("mid_arvalid", {63'h0, M_AXI_ARVALID}, 64'd1);
    tick();
    @(negedge ACLK);
    chk("mid_rready", {63'h0, M_AXI_RREADY}, 64'd1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_outputs", {58'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                            M_AXI_RREADY, resp_valid}, 64'h0);
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 64'h7777_7777_7777_7777;
    tick();
    tick();
    ARESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("post_rst_no_resp", {62'h0, resp_valid, req_ready}, 64'd1);
      chk("post_rst_rdata", resp_rdata, 64'h0);
      tick();
    end
    clear_slave();
    run_txn(mk(1'b0, 32'h0000_0040, 64'h0BAD_F00D_0BAD_F00D, 8'h00, 0, 0, 0, 0, 0, 2'b00, 3, 1'b0,
               64'h0BAD_F00D_0BAD_F00D), "post_rst_read");

    // Back-to-back: req_valid held high across a read then a write
    tick();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0060;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 64'h5555_AAAA_5555_AAAA; M_AXI_RRESP = 2'b00;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BRESP = 2'b00;
    @(negedge ACLK);
    chk("b2b_c0_ready", {63'h0, req_ready}, 64'd1);
    tick();
    req_wen = 1'b1; req_addr = 32'h0000_0080; req_wdata = 64'h1234_5678_9ABC_DEF0; req_wstrb = 8'hFF;
    @(negedge ACLK);
    chk("b2b_c1", {62'h0, M_AXI_ARVALID, req_ready}, 64'b10);
    tick();
    @(negedge ACLK);
    chk("b2b_c2", {62'h0, M_AXI_RREADY, M_AXI_ARVALID}, 64'b10);
    tick();
    @(negedge ACLK);
    chk("b2b_c3_flags", {58'h0, resp_valid, req_ready, M_AXI_ARVALID, M_AXI_AWVALID,
                         M_AXI_WVALID, M_AXI_RREADY}, 64'b110000);
    chk("b2b_c3_rdata", resp_rdata, 64'h5555_AAAA_5555_AAAA);
    tick();
    req_valid = 1'b0;
    M_AXI_BVALID = 1'b1;
    @(negedge ACLK);
    chk("b2b_c4_flags", {59'h0, resp_valid, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID,
                         M_AXI_BREADY}, 64'b00110);
    chk("b2b_c4_awaddr", {32'h0, M_AXI_AWADDR}, 64'h80);
    chk("b2b_c4_wdata", M_AXI_WDATA, 64'h1234_5678_9ABC_DEF0);
    tick();
    @(negedge ACLK);
    chk("b2b_c5", {60'h0, resp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 64'b0001);
    tick();
    @(negedge ACLK);
    chk("b2b_c6", {61'h0, resp_valid, resp_err, M_AXI_BREADY}, 64'b100);
    chk("b2b_c6_rdata", resp_rdata, 64'h5555_AAAA_5555_AAAA);
    tick();
    clear_slave();
    @(negedge ACLK);
    chk("b2b_c7", {62'h0, resp_valid, req_ready}, 64'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
